// File: rtl/instr_mem_loader.sv
`default_nettype none
// ============================================================================
// Module  : instr_mem_loader
// Purpose : Instruction RAM with length-prefixed byte-stream loader; holds the
//           core in reset until a full image is written. Optional checksum
//           byte enabled by macro LOADER_CHECKSUM_EN.
// Revision: 1.0
// ============================================================================
module instr_mem_loader #(
    parameter int MEM_WORDS = 1024
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_req_i,
    input  logic [7:0]  byte_i,
    input  logic        byte_valid_i,
    output logic        byte_ready_o,
    input  logic [31:0] addr_i,
    output logic [31:0] read_data_o,
    output logic        cpu_rst_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o
);
    localparam int          AW        = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [16:0] LEN_LIMIT = 17'(MEM_WORDS);
    localparam logic [29:0] FETCH_LIM = 30'(MEM_WORDS);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LEN0 = 3'd1,
        LEN1 = 3'd2,
        DATA = 3'd3,
        CSUM = 3'd4,
        RUN  = 3'd5,
        ERR  = 3'd6
    } state_t;

    state_t      state;
    logic [15:0] n;
    logic [15:0] k;
    logic [1:0]  bidx;
    logic [23:0] part;
    logic        done;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  csum;
`endif

    logic [31:0] mem [MEM_WORDS];

    logic        accept;
    logic [15:0] n_full;
    logic        write_en;
    logic        last_word;
    logic [1:0]  addr_unused;

    assign accept      = byte_valid_i && byte_ready_o;
    assign n_full      = {byte_i, n[7:0]};
    assign write_en    = (state == DATA) && accept && (bidx == 2'd3);
    assign last_word   = (k == n - 16'd1);
    assign addr_unused = addr_i[1:0];

    assign byte_ready_o = (state == LEN0) || (state == LEN1) ||
                          (state == DATA) || (state == CSUM);
    assign busy_o       = byte_ready_o;
    assign cpu_rst_o    = (state != RUN);
    assign err_o        = (state == ERR);
    assign done_o       = done;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
            n     <= 16'd0;
            k     <= 16'd0;
            bidx  <= 2'd0;
            part  <= 24'd0;
            done  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum  <= 8'd0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, RUN, ERR: begin
                    if (load_req_i) state <= LEN0;
                end
                LEN0: begin
                    if (accept) begin
                        n[7:0] <= byte_i;
                        state  <= LEN1;
                    end
                end
                LEN1: begin
                    if (accept) begin
                        n[15:8] <= byte_i;
                        k       <= 16'd0;
                        bidx    <= 2'd0;
                        part    <= 24'd0;
`ifdef LOADER_CHECKSUM_EN
                        csum    <= 8'd0;
`endif
                        if ({1'b0, n_full} > LEN_LIMIT) begin
                            state <= ERR;
                        end else if (n_full == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
                            state <= CSUM;
`else
                            state <= RUN;
                            done  <= 1'b1;
`endif
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (accept) begin
                        bidx <= bidx + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                        csum <= csum ^ byte_i;
`endif
                        case (bidx)
                            2'd0:    part[7:0]   <= byte_i;
                            2'd1:    part[15:8]  <= byte_i;
                            2'd2:    part[23:16] <= byte_i;
                            default: begin
                                // Fourth byte: RAM write happens in the memory block.
                                k <= k + 16'd1;
                                if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
                                    state <= CSUM;
`else
                                    state <= RUN;
                                    done  <= 1'b1;
`endif
                                end
                            end
                        endcase
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                CSUM: begin
                    if (accept) begin
                        if (byte_i == csum) begin
                            state <= RUN;
                            done  <= 1'b1;
                        end else begin
                            state <= ERR;
                        end
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

    // RAM contents deliberately survive reset.
    always_ff @(posedge clk_i) begin
        if (write_en) mem[k[AW-1:0]] <= {byte_i, part};
    end

    always_comb begin
        read_data_o = 32'h0;
        if (addr_i[31:2] < FETCH_LIM) read_data_o = mem[addr_i[AW+1:2]];
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_mem_loader.sv
`default_nettype none
// ============================================================================
// Module  : tb_instr_mem_loader
// Purpose : Directed self-checking bench for instr_mem_loader.
// Revision: 1.0
// ============================================================================
module tb_instr_mem_loader;
    logic        clk = 1'b0;
    logic        rst;
    logic        load_req;
    logic [7:0]  byte_d;
    logic        byte_valid;
    logic        byte_ready;
    logic [31:0] addr;
    logic [31:0] read_data;
    logic        cpu_rst;
    logic        busy;
    logic        done;
    logic        err;

    int checks    = 0;
    int failures  = 0;
    int done_cnt  = 0;
    int done_base = 0;
    logic [7:0] q[$];

    always #5 clk = ~clk;

    instr_mem_loader #(.MEM_WORDS(1024)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .load_req_i   (load_req),
        .byte_i       (byte_d),
        .byte_valid_i (byte_valid),
        .byte_ready_o (byte_ready),
        .addr_i       (addr),
        .read_data_o  (read_data),
        .cpu_rst_o    (cpu_rst),
        .busy_o       (busy),
        .done_o       (done),
        .err_o        (err)
    );

    // Count done pulses a little after each edge, clear of the sampling negedge.
    always begin
        @(posedge clk);
        #2;
        if (done === 1'b1) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        check(tag, read_data, exp);
    endtask

    // Called just after a negedge; returns just after the negedge following the accept.
    task automatic send(input logic [7:0] b, input bit gap);
        int t;
        byte_d     = b;
        byte_valid = 1'b1;
        t = 0;
        while (byte_ready !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) check("ready_timeout", {31'd0, byte_ready}, 32'd1);
        @(negedge clk);
        if (gap) begin
            byte_valid = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic stream(input bit gap);
        foreach (q[i]) send(q[i], gap);
        byte_valid = 1'b0;
    endtask

    task automatic add_csum();
`ifdef LOADER_CHECKSUM_EN
        logic [7:0] x;
        x = 8'h00;
        for (int i = 2; i < q.size(); i++) x ^= q[i];
        q.push_back(x);
`endif
    endtask

    task automatic request();
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
    endtask

    initial begin
        rst = 1'b1; load_req = 1'b0; byte_d = 8'h00; byte_valid = 1'b0; addr = 32'h0;
        repeat (2) @(negedge clk);
        check("rst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        check("rst_ready", {31'd0, byte_ready}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_cpu_rst", {31'd0, cpu_rst}, 32'd1);

        // Basic two-word load at full rate.
        q = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'hB3, 8'h00, 8'hA0, 8'h00};
        add_csum();
        done_base = done_cnt;
        request();
        check("t1_busy_len0", {31'd0, busy}, 32'd1);
        stream(1'b0);
        check("t1_done_hi", {31'd0, done}, 32'd1);
        check("t1_cpu_rst_lo", {31'd0, cpu_rst}, 32'd0);
        check("t1_ready_lo", {31'd0, byte_ready}, 32'd0);
        check("t1_busy_lo", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check("t1_done_lo", {31'd0, done}, 32'd0);
        check("t1_done_cnt", done_cnt - done_base, 32'd1);
        rd("t1_mem0", 32'd0, 32'h0000_0013);
        rd("t1_mem1", 32'd4, 32'h00A0_00B3);
        rd("t1_mem1_unal", 32'd7, 32'h00A0_00B3);
        rd("t1_oob", 32'd4096, 32'h0);

        // Zero-length image: straight to RUN, RAM untouched.
        q = '{8'h00, 8'h00};
        add_csum();
        done_base = done_cnt;
        request();
        stream(1'b0);
        @(negedge clk);
        check("z_cpu_rst", {31'd0, cpu_rst}, 32'd0);
        check("z_done_cnt", done_cnt - done_base, 32'd1);
        rd("z_mem0", 32'd0, 32'h0000_0013);
        rd("z_mem1", 32'd4, 32'h00A0_00B3);

        // Oversized length, then recovery with a gapped stream of new data.
        q = '{8'h01, 8'h04};
        done_base = done_cnt;
        request();
        stream(1'b0);
        check("e_err", {31'd0, err}, 32'd1);
        check("e_ready", {31'd0, byte_ready}, 32'd0);
        check("e_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        check("e_busy", {31'd0, busy}, 32'd0);
        check("e_done_cnt", done_cnt - done_base, 32'd0);
        q = '{8'h02, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h0D, 8'hF0, 8'hFE, 8'hCA};
        add_csum();
        request();
        stream(1'b1);
        check("r_err", {31'd0, err}, 32'd0);
        check("r_cpu_rst", {31'd0, cpu_rst}, 32'd0);
        check("r_done_cnt", done_cnt - done_base, 32'd1);
        rd("r_mem0", 32'd0, 32'hDEAD_BEEF);
        rd("r_mem1", 32'd4, 32'hCAFE_F00D);

        // Reset after 6 of 10 bytes: word 0 written, word 1 untouched.
        q = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00};
        request();
        stream(1'b0);
        check("p_busy_mid", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        check("p_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        check("p_ready", {31'd0, byte_ready}, 32'd0);
        check("p_busy", {31'd0, busy}, 32'd0);
        check("p_done", {31'd0, done}, 32'd0);
        check("p_err", {31'd0, err}, 32'd0);
        rd("p_mem0", 32'd0, 32'h0000_0013);
        rd("p_mem1", 32'd4, 32'hCAFE_F00D);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("p_idle_cpu_rst", {31'd0, cpu_rst}, 32'd1);

        // Same image with byte_valid low on alternate cycles.
        q = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'hB3, 8'h00, 8'hA0, 8'h00};
        add_csum();
        done_base = done_cnt;
        request();
        stream(1'b1);
        @(negedge clk);
        check("g_done_cnt", done_cnt - done_base, 32'd1);
        check("g_cpu_rst", {31'd0, cpu_rst}, 32'd0);
        rd("g_mem0", 32'd0, 32'h0000_0013);
        rd("g_mem1", 32'd4, 32'h00A0_00B3);

`ifdef LOADER_CHECKSUM_EN
        q = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00};
        request();
        stream(1'b0);
        check("c_bad_err", {31'd0, err}, 32'd1);
        check("c_bad_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        q = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
        request();
        stream(1'b0);
        check("c_ok_err", {31'd0, err}, 32'd0);
        check("c_ok_cpu_rst", {31'd0, cpu_rst}, 32'd0);
        rd("c_mem0", 32'd0, 32'h4433_2211);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
